// File: rtl/bpc_pkg.sv
// bpc_pkg: shared FSM state type and derived-size helpers for the bit-plane compression encoder.
package bpc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, EMIT = 2'd2} state_t;
    function automatic int dlt_w(input int word_w);
        return word_w + 1;
    endfunction
    function automatic int blk_words(input int lanes, input int blk_beats);
        return lanes * blk_beats;
    endfunction
    function automatic int n_planes(input int word_w);
        return word_w + 1;
    endfunction
    function automatic int n_out(input int word_w);
        return word_w + 2;
    endfunction
endpackage

// File: rtl/bpc_delta_lane.sv
// bpc_delta_lane: one word-to-word delta, both operands sign-extended by one bit.
module bpc_delta_lane
    import bpc_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0]        cur,
    input  logic [WORD_W-1:0]        prev,
    output logic [dlt_w(WORD_W)-1:0] dlt
);
    assign dlt = {cur[WORD_W-1], cur} - {prev[WORD_W-1], prev};
endmodule

// File: rtl/bpc_dbx_xform.sv
// bpc_dbx_xform: collects one block, then emits the base word and the delta bit-planes.
// BPC_DBX_EN defined: planes are XORed with the next-higher plane; undefined: raw planes.
module bpc_dbx_xform
    import bpc_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int LANES     = 4,
    parameter int BLK_BEATS = 16,
    parameter int OUT_W     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*WORD_W-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    sop_i,
    input  logic                    eop_i,
    output logic [OUT_W-1:0]        data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    sop_o,
    output logic                    eop_o,
    output logic                    err_o
);
    localparam int DATA_W    = LANES * WORD_W;
    localparam int DLT_W     = dlt_w(WORD_W);
    localparam int BLK_WORDS = blk_words(LANES, BLK_BEATS);
    localparam int N_OUT     = n_out(WORD_W);
    localparam int IW        = $clog2(BLK_WORDS);
    localparam int CW        = $clog2(BLK_BEATS);
    localparam int OW        = $clog2(N_OUT);
    localparam int PW        = $clog2(n_planes(WORD_W) + 1);

    state_t                 state;
    logic [WORD_W-1:0]      base;
    logic [WORD_W-1:0]      prev;
    logic [WORD_W-1:0]      w   [LANES];
    logic [DLT_W-1:0]       dl  [LANES];
    logic [DLT_W-1:0]       d   [BLK_WORDS];
    logic [CW-1:0]          cnt;
    logic [OW-1:0]          ocnt;
    logic [IW-1:0]          widx;
    logic                   acc;
    logic                   take;
    logic                   last_beat;
    logic                   close;
    logic                   err;
    logic [PW-1:0]          pl;
    logic [PW-1:0]          ph;
    logic [BLK_WORDS-2:0]   raw;
    logic [BLK_WORDS-2:0]   up;
    logic [BLK_WORDS-2:0]   plane;
    logic [OUT_W-1:0]       nxt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w[i] = data_i[DATA_W-1-i*WORD_W -: WORD_W];
        if (i == 0) begin : g_first
            bpc_delta_lane #(.WORD_W(WORD_W)) u_dl (.cur(w[i]), .prev(prev), .dlt(dl[i]));
        end else begin : g_rest
            bpc_delta_lane #(.WORD_W(WORD_W)) u_dl (.cur(w[i]), .prev(w[i-1]), .dlt(dl[i]));
        end
    end

    assign ready_o   = state != EMIT;
    assign acc       = valid_i && ready_o;
    assign take      = acc && (sop_i || state == FILL);
    assign last_beat = !sop_i && cnt == CW'(BLK_BEATS - 1);
    assign close     = eop_i || last_beat;
    assign widx      = sop_i ? '0 : IW'(cnt * LANES);
    assign err       = acc && ((state == IDLE && !sop_i) || (state == FILL && (sop_i || (last_beat && !eop_i))));

    // Plane index for output beat n (n >= 1) is WORD_W+1-n; beat 0 carries the base word.
    always_comb begin
        pl = (ocnt == '0) ? '0 : PW'(N_OUT - 1) - PW'(ocnt);
        ph = pl + 1'b1;
        raw = '0;
        up = '0;
        for (int k = 1; k < BLK_WORDS; k++) begin
            raw[k-1] = d[k][pl];
            up[k-1]  = (pl < PW'(WORD_W)) ? d[k][ph] : 1'b0;
        end
`ifdef BPC_DBX_EN
        plane = raw ^ up;
`else
        plane = raw;
`endif
        nxt = (ocnt == '0) ? OUT_W'(base) : OUT_W'(plane);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            prev    <= '0;
            cnt     <= '0;
            ocnt    <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
            err_o   <= 1'b0;
            for (int k = 0; k < BLK_WORDS; k++) d[k] <= '0;
        end else begin
            err_o <= err;
            if (take) begin
                // A new block clears the store so unfilled (padded) words read as zero deltas.
                if (sop_i) begin
                    for (int k = 0; k < BLK_WORDS; k++) d[k] <= '0;
                    base <= w[0];
                end
                for (int i = 0; i < LANES; i++)
                    if (!(sop_i && i == 0)) d[widx + IW'(i)] <= dl[i];
                prev  <= w[LANES-1];
                cnt   <= sop_i ? CW'(1) : cnt + 1'b1;
                ocnt  <= '0;
                state <= close ? EMIT : FILL;
            end
            if (state == EMIT) begin
                if (valid_o && ready_i && eop_o) begin
                    valid_o <= 1'b0;
                    sop_o   <= 1'b0;
                    eop_o   <= 1'b0;
                    state   <= IDLE;
                end else if (!valid_o || ready_i) begin
                    data_o  <= nxt;
                    valid_o <= 1'b1;
                    sop_o   <= ocnt == '0;
                    eop_o   <= ocnt == OW'(N_OUT - 1);
                    ocnt    <= ocnt + 1'b1;
                end
            end
        end
    end
endmodule
